nd_2to1_arb: RTL and testbench

//  Arbitrated 2-to-1 merge node for message links. Two upstream channels (rcv0, rcv1) share one downstream channel (snd0).

---
 rtl/nd_2to1_arb.sv | 114 +++++++++++
 tb/tb_nd_2to1_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: arbitrated 2-to-1 merge of 4-phase req/ack message links
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_rcvN_req/i_rcvN_dat/o_rcvN_ack   upstream channels 0 and 1
//   o_snd0_req/o_snd0_dat/i_snd0_ack   downstream channel
//   o_last_src/o_busy/o_cnt0/o_cnt1/o_err   debug: last winner, not idle, per-source counts, sticky ack timeout
module nd_2to1_arb #(
  parameter int DSZ = 8,
  parameter int PRIO_FIX = 0,
  parameter int CNT_SZ = 8,
  parameter int TMO_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rcv0_req,
  input  logic [DSZ-1:0]    i_rcv0_dat,
  output logic              o_rcv0_ack,
  input  logic              i_rcv1_req,
  input  logic [DSZ-1:0]    i_rcv1_dat,
  output logic              o_rcv1_ack,
  output logic              o_snd0_req,
  output logic [DSZ-1:0]    o_snd0_dat,
  input  logic              i_snd0_ack,
  output logic              o_last_src,
  output logic              o_busy,
  output logic [CNT_SZ-1:0] o_cnt0,
  output logic [CNT_SZ-1:0] o_cnt1,
  output logic              o_err
);
  localparam int TW = TMO_CYC < 2 ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  typedef enum logic [1:0] {IDLE, FWD, RLS} state_t;
  state_t state_q, state_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic req_q, req_d, ack0_q, ack0_d, ack1_q, ack1_d, last_q, last_d, err_q, err_d;
  logic [CNT_SZ-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic gnt, src_req;
  // contested grant: fixed priority favours rcv0, round-robin hands it to the previous loser
  assign gnt = (i_rcv0_req & i_rcv1_req) ? ((PRIO_FIX != 0) ? 1'b0 : ~last_q) : i_rcv1_req;
  assign src_req = last_q ? i_rcv1_req : i_rcv0_req;
  always_comb begin
    state_d = state_q;
    dat_d = dat_q;
    req_d = req_q;
    ack0_d = ack0_q;
    ack1_d = ack1_q;
    last_d = last_q;
    err_d = err_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    tmo_d = tmo_q;
    case (state_q)
      IDLE: if (!i_snd0_ack && (i_rcv0_req || i_rcv1_req)) begin
        state_d = FWD;
        dat_d = gnt ? i_rcv1_dat : i_rcv0_dat;
        req_d = 1'b1;
        last_d = gnt;
        tmo_d = '0;
      end
      FWD: if (i_snd0_ack) begin
        state_d = RLS;
        req_d = 1'b0;
        ack0_d = ~last_q;
        ack1_d = last_q;
      end else begin
        tmo_d = (tmo_q != TMO_MAX) ? tmo_q + 1'b1 : tmo_q;
        err_d = err_q | ((TMO_CYC != 0) && (tmo_q == TMO_LAST));
      end
      RLS: if (!src_req && !i_snd0_ack) begin
        state_d = IDLE;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        cnt0_d = last_q ? cnt0_q : cnt0_q + 1'b1;
        cnt1_d = last_q ? cnt1_q + 1'b1 : cnt1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      dat_q <= '0;
      req_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      last_q <= 1'b1;
      err_q <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      dat_q <= dat_d;
      req_q <= req_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      last_q <= last_d;
      err_q <= err_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      tmo_q <= tmo_d;
    end
  end
  assign o_rcv0_ack = ack0_q;
  assign o_rcv1_ack = ack1_q;
  assign o_snd0_req = req_q;
  assign o_snd0_dat = dat_q;
  assign o_last_src = last_q;
  assign o_busy = state_q != IDLE;
  assign o_cnt0 = cnt0_q;
  assign o_cnt1 = cnt1_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_nd_2to1_arb.sv
// tb_nd_2to1_arb: scoreboard bench driving a round-robin (inst0) and a fixed-priority (inst1) arbiter
module tb_nd_2to1_arb;
  logic clk = 1'b0;
  logic rst = 1'b1, sink_en = 1'b1, stale = 1'b0, hold = 1'b0;
  int total = 0, bad = 0;
  logic [7:0] mq [4][$];
  logic [8:0] eq [2][$];
  logic sreq_a[2], last_a[2], busy_a[2], err_a[2], rq_a[4], ak_a[4];
  logic [7:0] sdat_a[2];
  logic [1:0] c0_a[2], c1_a[2];
  logic prev[2] = '{1'b0, 1'b0};
  logic [8:0] exp_v;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 2; k++) begin : g
    logic r0 = 1'b0, r1 = 1'b0, sa = 1'b0;
    logic a0, a1, sr, ls, bz, er;
    logic [7:0] d0 = 8'd0, d1 = 8'd0, sd;
    logic [1:0] c0, c1;
    nd_2to1_arb #(.DSZ(8), .PRIO_FIX(k), .CNT_SZ(2), .TMO_CYC(10)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rcv0_req(r0), .i_rcv0_dat(d0), .o_rcv0_ack(a0),
      .i_rcv1_req(r1), .i_rcv1_dat(d1), .o_rcv1_ack(a1),
      .o_snd0_req(sr), .o_snd0_dat(sd), .i_snd0_ack(sa),
      .o_last_src(ls), .o_busy(bz), .o_cnt0(c0), .o_cnt1(c1), .o_err(er)
    );
    always @(negedge clk) begin
      if (rst) begin
        r0 = 1'b0;
        r1 = 1'b0;
      end else begin
        if (r0 && a0 && !hold) begin
          r0 = 1'b0;
          void'(mq[2*k].pop_front());
        end else if (!r0 && !a0 && mq[2*k].size() > 0) begin
          r0 = 1'b1;
          d0 = mq[2*k][0];
        end
        if (r1 && a1 && !hold) begin
          r1 = 1'b0;
          void'(mq[2*k+1].pop_front());
        end else if (!r1 && !a1 && mq[2*k+1].size() > 0) begin
          r1 = 1'b1;
          d1 = mq[2*k+1][0];
        end
      end
      sa = stale | (sink_en & sr);
    end
    assign sreq_a[k] = sr;
    assign sdat_a[k] = sd;
    assign last_a[k] = ls;
    assign busy_a[k] = bz;
    assign err_a[k] = er;
    assign c0_a[k] = c0;
    assign c1_a[k] = c1;
    assign rq_a[2*k] = r0;
    assign rq_a[2*k+1] = r1;
    assign ak_a[2*k] = a0;
    assign ak_a[2*k+1] = a1;
  end
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (sreq_a[k] && !prev[k]) begin
        total++;
        if (eq[k].size() == 0) begin
          bad++;
          $display("FAIL grant inst%0d: got src=%0d dat=%0h, expected no grant", k, last_a[k], sdat_a[k]);
        end else begin
          exp_v = eq[k].pop_front();
          if ({last_a[k], sdat_a[k]} !== exp_v) begin
            bad++;
            $display("FAIL grant inst%0d: got src=%0d dat=%0h, expected src=%0d dat=%0h", k, last_a[k], sdat_a[k], exp_v[8], exp_v[7:0]);
          end
        end
      end
      prev[k] = sreq_a[k];
    end
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(int k, string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL inst%0d %s: got %0d expected %0d", k, nm, act, exp);
    end
  endtask
  task automatic msg(int s, logic [7:0] d);
    mq[s].push_back(d);
    mq[2+s].push_back(d);
  endtask
  task automatic expg(int k, int s, logic [7:0] d);
    eq[k].push_back({s[0], d});
  endtask
  task automatic both(int s, logic [7:0] d);
    msg(s, d);
    expg(0, s, d);
    expg(1, s, d);
  endtask
  task automatic wait_idle(string nm);
    int n = 0;
    while (!(mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && mq[3].size() == 0 &&
             eq[0].size() == 0 && eq[1].size() == 0 && !busy_a[0] && !busy_a[1]) && n < 300) begin
      step();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, n);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    eq[0].delete();
    eq[1].delete();
  endtask
  initial begin
    step(2);
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst sreq", sreq_a[k], 0);
      chk(k, "rst ack0", ak_a[2*k], 0);
      chk(k, "rst ack1", ak_a[2*k+1], 0);
      chk(k, "rst err", err_a[k], 0);
      chk(k, "rst cnt0", c0_a[k], 0);
      chk(k, "rst cnt1", c1_a[k], 0);
      chk(k, "rst last", last_a[k], 1);
      chk(k, "rst busy", busy_a[k], 0);
      chk(k, "rst dat", sdat_a[k], 0);
    end
    both(0, 8'h05);
    step();
    for (int k = 0; k < 2; k++) chk(k, "single req latency", sreq_a[k], 1);
    wait_idle("single");
    for (int k = 0; k < 2; k++) begin
      chk(k, "single cnt0", c0_a[k], 1);
      chk(k, "single cnt1", c1_a[k], 0);
    end
    stale = 1'b1;
    both(0, 8'h06);
    step(5);
    for (int k = 0; k < 2; k++) begin
      chk(k, "stale ack no grant", sreq_a[k], 0);
      chk(k, "stale ack busy", busy_a[k], 0);
    end
    stale = 1'b0;
    wait_idle("stale");
    for (int k = 0; k < 2; k++) chk(k, "stale cnt0", c0_a[k], 2);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      msg(0, 8'h10 + 8'(i));
      msg(1, 8'h20 + 8'(i));
    end
    expg(0, 0, 8'h10); expg(0, 1, 8'h20); expg(0, 0, 8'h11);
    expg(0, 1, 8'h21); expg(0, 0, 8'h12); expg(0, 1, 8'h22);
    expg(1, 0, 8'h10); expg(1, 0, 8'h11); expg(1, 0, 8'h12);
    expg(1, 1, 8'h20); expg(1, 1, 8'h21); expg(1, 1, 8'h22);
    wait_idle("contended");
    for (int k = 0; k < 2; k++) begin
      chk(k, "contended cnt0", c0_a[k], 3);
      chk(k, "contended cnt1", c1_a[k], 3);
    end
    do_reset();
    sink_en = 1'b0;
    both(0, 8'h07);
    step();
    step(9);
    for (int k = 0; k < 2; k++) chk(k, "tmo err before 10", err_a[k], 0);
    step();
    for (int k = 0; k < 2; k++) begin
      chk(k, "tmo err at 10", err_a[k], 1);
      chk(k, "tmo req held", sreq_a[k], 1);
      chk(k, "tmo busy", busy_a[k], 1);
    end
    sink_en = 1'b1;
    wait_idle("late ack");
    for (int k = 0; k < 2; k++) begin
      chk(k, "late ack err sticky", err_a[k], 1);
      chk(k, "late ack cnt0", c0_a[k], 1);
    end
    hold = 1'b1;
    both(0, 8'h09);
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk(k, "rls ack0", ak_a[2*k], 1);
      chk(k, "rls last", last_a[k], 0);
    end
    do_reset();
    hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk(k, "midrst ack0", ak_a[2*k], 0);
      chk(k, "midrst sreq", sreq_a[k], 0);
      chk(k, "midrst cnt0", c0_a[k], 0);
      chk(k, "midrst last", last_a[k], 1);
      chk(k, "midrst err", err_a[k], 0);
      chk(k, "midrst busy", busy_a[k], 0);
    end
    for (int i = 0; i < 5; i++) both(1, 8'h31 + 8'(i));
    wait_idle("wrap");
    for (int k = 0; k < 2; k++) begin
      chk(k, "wrap cnt1", c1_a[k], 1);
      chk(k, "wrap cnt0", c0_a[k], 0);
      chk(k, "wrap err", err_a[k], 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
